frame_sched: RTL and testbench
==============================

FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter: SCAN_TIMEOUT, default 200000, cycles allowed between scan_start and scan_done before the scan is declared hung.
REQ-002 Parameter: CNT_W, default 18, width of the watchdog counter; SCAN_TIMEOUT SHALL be no greater than 2**CNT_W-1.
REQ-003 Port: clk  in  1  system clock; all logic on posedge clk.
REQ-004 Port: reset  in  1  synchronous, active-low reset.
REQ-005 Port: wr_done  in  1  one-cycle pulse from the SPI board receiver: the back buffer holds a complete 32x32 board.
REQ-006 Port: scan_done  in  1  one-cycle pulse from the LED scanner: all 16 row pairs have been shifted out and latched.
REQ-007 Port: scan_start  out  1  one-cycle pulse: the scanner begins a frame from row 0 using the front buffer.
REQ-008 Port: front_sel  out  1  index (0/1) of the buffer read by the scanner; the writer uses ~front_sel.
REQ-009 Port: wr_ready  out  1  high when the back buffer may be overwritten by the SPI receiver.
REQ-010 Port: frame_cnt  out  16  count of completed scans.
REQ-011 Port: drop_cnt  out  8  count of rejected wr_done pulses.
REQ-012 Port: timeout_err  out  1  sticky flag: the scan watchdog has fired.

Function
REQ-013 FSM states: S_IDLE, S_START, S_SCAN, S_SWAP.
REQ-014 S_IDLE SHALL go to S_START on the first cycle with reset high.
REQ-015 S_START SHALL last exactly one cycle and go to S_SCAN.
REQ-016 scan_start SHALL be a Moore decode of state == S_START.
REQ-017 S_SCAN: on scan_done, go to S_SWAP if swap_go is set, else go to S_START.
REQ-018 swap_go = swap_pending OR (wr_done AND wr_ready) in the same cycle.
REQ-019 S_SWAP SHALL last one cycle: toggle front_sel, clear swap_pending, set wr_ready, then go to S_START.
REQ-020 wr_done while wr_ready=1 SHALL set swap_pending and clear wr_ready on the next edge.
REQ-021 wr_done while wr_ready=0 SHALL be ignored; drop_cnt increments and saturates at 255.
REQ-022 front_sel SHALL change only in S_SWAP, so the scanner never sees a buffer change mid-frame.
REQ-023 frame_cnt SHALL increment on every scan_done accepted in S_SCAN and wrap 65535 -> 0.
REQ-024 scan_done outside S_SCAN SHALL be ignored: no state change, no count.
REQ-025 Watchdog: cleared in S_START, increments each cycle in S_SCAN.
REQ-026 When the watchdog reaches SCAN_TIMEOUT-1 without scan_done: set timeout_err and go to S_START; swap_pending and front_sel are unchanged; frame_cnt does not increment.
REQ-027 timeout_err SHALL clear only on reset.
REQ-028 Timing: scan_done to the next scan_start is 1 cycle without a swap and 2 cycles with a swap.

Reset
REQ-029 While reset=0 at posedge clk: state=S_IDLE, scan_start=0, front_sel=0, wr_ready=1, swap_pending=0, frame_cnt=0, drop_cnt=0, timeout_err=0, watchdog=0.
REQ-030 Reset asserted mid-scan or mid-swap SHALL abandon the operation with no partial toggle of front_sel.
REQ-031 The first scan_start SHALL occur 2 cycles after reset deasserts.

Structure
REQ-032 A shared package frame_sched_pkg SHALL hold the state enum typedef, the default SCAN_TIMEOUT and the default CNT_W.
REQ-033 One sub-module, scan_watchdog, SHALL be used: clear/enable inputs and an expired output, parameterised by SCAN_TIMEOUT and CNT_W.
REQ-034 All outputs SHALL be driven from registers or state decode only, with no combinational path from inputs.

Verification
REQ-035 Reset release, scan_done returned 10 cycles after each scan_start -> first scan_start at cycle 2, front_sel stays 0, frame_cnt=3 after 3 scans.
REQ-036 wr_done mid-scan, then scan_done -> wr_ready=0 until S_SWAP, front_sel=1 from the swap cycle, next scan_start 2 cycles after scan_done.
REQ-037 wr_done and scan_done in the same cycle with wr_ready=1 -> swap occurs in that frame, front_sel toggles, drop_cnt=0.
REQ-038 300 wr_done pulses while wr_ready=0 -> drop_cnt saturates at 255, front_sel unchanged.
REQ-039 scan_done withheld with SCAN_TIMEOUT=50 -> timeout_err=1 at cycle 49 of S_SCAN, scan_start re-issued, frame_cnt unchanged, swap_pending preserved.
REQ-040 reset pulsed low in S_SWAP with front_sel=1 -> all outputs at REQ-029 values, front_sel=0, wr_ready=1.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and default parameters for the frame buffer scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_SCAN,
    S_SWAP
  } state_t;

  localparam int unsigned DEF_SCAN_TIMEOUT = 200000;
  localparam int unsigned DEF_CNT_W        = 18;

endpackage

// File: rtl/frame_sched_scan_watchdog.sv
// Scan watchdog: counts cycles spent scanning and flags a hung scanner.
module scan_watchdog
  import frame_sched_pkg::*;
#(
  parameter int unsigned SCAN_TIMEOUT = DEF_SCAN_TIMEOUT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SCAN_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Hold at the limit so a stalled count can never wrap back to zero.
  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/frame_sched.sv
// Double-buffered frame scheduler: sequences LED scans and swaps the
// front/back board buffers only between frames.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int unsigned SCAN_TIMEOUT = DEF_SCAN_TIMEOUT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_done,
  input  logic        scan_done,
  output logic        scan_start,
  output logic        front_sel,
  output logic        wr_ready,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt,
  output logic        timeout_err
);

  state_t state;
  state_t state_nxt;
  logic   swap_pending;
  logic   wr_accept;
  logic   swap_go;
  logic   wd_expired;
  logic   scan_end;

  assign wr_accept = wr_done && wr_ready;
  assign swap_go   = swap_pending || wr_accept;
  assign scan_end  = (state == S_SCAN) && scan_done;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_START;
      S_START: state_nxt = S_SCAN;
      S_SCAN: begin
        if (scan_done) begin
          state_nxt = swap_go ? S_SWAP : S_START;
        end else if (wd_expired) begin
          state_nxt = S_START;
        end
      end
      S_SWAP:  state_nxt = S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      front_sel    <= 1'b0;
      wr_ready     <= 1'b1;
      swap_pending <= 1'b0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (wr_accept) begin
        swap_pending <= 1'b1;
        wr_ready     <= 1'b0;
      end else if (wr_done && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      // wr_ready is always low here, so this never collides with wr_accept.
      if (state == S_SWAP) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
        wr_ready     <= 1'b1;
      end

      if (scan_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (state == S_SCAN && !scan_done && wd_expired) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign scan_start = (state == S_START);

  scan_watchdog #(
    .SCAN_TIMEOUT(SCAN_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == S_START),
    .enable (state == S_SCAN),
    .expired(wd_expired)
  );

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_frame_sched;

  localparam int TO = 50;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_SCAN  = 2;
  localparam int P_SWAP  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_done = 1'b0;
  logic        scan_done = 1'b0;
  logic        scan_start;
  logic        front_sel;
  logic        wr_ready;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_phase;
  int m_age;
  int m_frames;
  int m_drops;
  bit m_front;
  bit m_ready;
  bit m_pending;
  bit m_terr;

  always #5 clk = ~clk;

  frame_sched #(
    .SCAN_TIMEOUT(TO),
    .CNT_W       (18)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_done    (wr_done),
    .scan_done  (scan_done),
    .scan_start (scan_start),
    .front_sel  (front_sel),
    .wr_ready   (wr_ready),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the scheduler's rules, applied to the given inputs.
  task automatic model_step(input bit r, input bit w, input bit s);
    if (!r) begin
      m_phase = P_IDLE; m_age = 0; m_frames = 0; m_drops = 0;
      m_front = 0; m_ready = 1; m_pending = 0; m_terr = 0;
      return;
    end
    if (w && m_ready) begin
      m_pending = 1;
      m_ready   = 0;
    end else if (w) begin
      m_drops = (m_drops == 255) ? 255 : m_drops + 1;
    end
    case (m_phase)
      P_IDLE:  m_phase = P_START;
      P_START: begin m_phase = P_SCAN; m_age = 0; end
      P_SCAN: begin
        if (s) begin
          m_frames = (m_frames + 1) % 65536;
          m_phase  = m_pending ? P_SWAP : P_START;
        end else if (m_age == TO - 1) begin
          m_terr  = 1;
          m_phase = P_START;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_front   = !m_front;
        m_pending = 0;
        m_ready   = 1;
        m_phase   = P_START;
      end
    endcase
  endtask

  task automatic compare_all();
    check("scan_start",  scan_start,  m_phase == P_START);
    check("front_sel",   front_sel,   m_front);
    check("wr_ready",    wr_ready,    m_ready);
    check("frame_cnt",   frame_cnt,   m_frames);
    check("drop_cnt",    drop_cnt,    m_drops);
    check("timeout_err", timeout_err, m_terr);
  endtask

  // Drive inputs for one cycle, advance the model at the edge, check at negedge.
  task automatic tick(input bit r, input bit w, input bit s);
    reset = r; wr_done = w; scan_done = s;
    @(posedge clk);
    model_step(r, w, s);
    @(negedge clk);
    compare_all();
  endtask

  // Starting in the scan_start cycle: return scan_done dly ticks later,
  // optionally pulsing wr_done on tick wd_at.
  task automatic do_scan(input int dly, input int wd_at);
    for (int k = 0; k < dly; k++) begin
      tick(1'b1, k == wd_at, k == dly - 1);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!scan_start && n < 10) begin
      tick(1'b1, 1'b0, 1'b0);
      n++;
    end
    check("wait_start_bound", n < 10, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cd;
    bit r, w, s;

    model_step(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("rst_scan_start", scan_start, 0);
    check("rst_front_sel",  front_sel,  0);
    check("rst_wr_ready",   wr_ready,   1);
    check("rst_frame_cnt",  frame_cnt,  0);

    // Second cycle with reset high carries the first scan_start.
    tick(1'b1, 1'b0, 1'b0);
    check("first_start_cycle2", scan_start, 1);

    // Three plain scans, 10 cycles each
    for (int i = 0; i < 3; i++) begin
      do_scan(10, -1);
      wait_start();
    end
    check("three_frames", frame_cnt, 3);
    check("three_front",  front_sel, 0);

    // wr_done mid-scan, then scan_done: swap takes two cycles to next start
    do_scan(10, 4);
    check("ready_low_swap", wr_ready, 0);
    check("swap_not_start", scan_start, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("swap_front1",  front_sel, 1);
    check("swap_ready1",  wr_ready, 1);
    check("swap_start_2", scan_start, 1);

    // wr_done and scan_done on the same cycle
    do_scan(10, 9);
    tick(1'b1, 1'b0, 1'b0);
    check("same_front0", front_sel, 0);
    check("same_drops0", drop_cnt, 0);
    check("same_start",  scan_start, 1);

    // Accept a write, then withhold scan_done until the watchdog fires
    tick(1'b1, 1'b1, 1'b0);
    repeat (49) tick(1'b1, 1'b0, 1'b0);
    check("to_not_yet", timeout_err, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("to_err_set",    timeout_err, 1);
    check("to_restart",    scan_start, 1);
    check("to_frames",     frame_cnt, 5);
    check("to_pending",    wr_ready, 0);

    // 300 rejected writes while the back buffer is still pending
    repeat (300) tick(1'b1, 1'b1, 1'b0);
    check("drop_sat",   drop_cnt, 255);
    check("drop_front", front_sel, 0);
    check("drop_terr",  timeout_err, 1);
    wait_start();
    do_scan(5, -1);
    tick(1'b1, 1'b0, 1'b0);
    check("pend_swap_front", front_sel, 1);
    check("pend_swap_ready", wr_ready, 1);

    // Reset during S_SWAP with front_sel=1
    wait_start();
    do_scan(8, 3);
    tick(1'b0, 1'b0, 1'b0);
    check("rsw_front", front_sel, 0);
    check("rsw_ready", wr_ready, 1);
    check("rsw_terr",  timeout_err, 0);
    check("rsw_drops", drop_cnt, 0);
    check("rsw_start", scan_start, 0);

    // Randomized run with a model-tracked scanner
    cd = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom % 600) != 0;
      w = ($urandom % 8) == 0;
      s = (cd == 1) || (($urandom % 25) == 0);
      tick(r, w, s);
      if (m_phase == P_START) cd = $urandom_range(2, 56);
      else if (cd > 0) cd--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
